// File: rtl/oled_spi_sink_pkg.sv
// Shared types and opcodes for the OLED SPI sink: parser states, argument kinds
// and the SSD1306 command subset that the sink recognises.
package oled_pkg;

  typedef enum logic [1:0] {P_CMD, P_ARG1, P_ARG2} pstate_t;
  typedef enum logic [1:0] {K_COL, K_PAGE, K_SKIP1} kind_t;

  localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
  localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;
  localparam logic [7:0] CMD_DISP_OFF  = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON   = 8'hAF;

  // Commands that take one argument byte which the sink does not interpret.
  function automatic logic is_skip1(input logic [7:0] b);
    case (b)
      8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: is_skip1 = 1'b1;
      default:                                                is_skip1 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/oled_spi_sink_if.sv
// OLED link bundle: SPI stream from the display driver plus the framebuffer
// write port and status outputs of the sink.
interface oled_spi_sink_if #(
  parameter int PAGES = 4,
  parameter int COLS  = 128
);
  localparam int PW = $clog2(PAGES);
  localparam int CW = $clog2(COLS);

  logic           sclk;
  logic           mosi;
  logic           dc;
  logic           fb_we;
  logic [PW+CW-1:0] fb_addr;
  logic [7:0]     fb_wdata;
  logic           cmd_valid;
  logic [7:0]     cmd_byte;
  logic           disp_on;
  logic           frame_done;

  modport master (
    output sclk, mosi, dc,
    input  fb_we, fb_addr, fb_wdata, cmd_valid, cmd_byte, disp_on, frame_done
  );

  modport slave (
    input  sclk, mosi, dc,
    output fb_we, fb_addr, fb_wdata, cmd_valid, cmd_byte, disp_on, frame_done
  );
endinterface

// File: rtl/oled_spi_sink_spi_byte_rx.sv
// SPI byte receiver: synchronises sclk/mosi/dc into clk, shifts MSB first and
// drops a partial byte after TIMEOUT idle clk cycles.
module spi_byte_rx #(
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       dc_i,
  output logic       byte_rdy_o,
  output logic [7:0] byte_o,
  output logic       byte_dc_o
);
  localparam int IW = $clog2(TIMEOUT + 1);

  logic [2:0]    sclk_q;
  logic [1:0]    mosi_q, dc_q;
  logic [6:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          rdy_q, rdy_d;
  logic [7:0]    byte_q, byte_d;
  logic          dc_lat_q, dc_lat_d;
  logic          rise;

  assign rise = sclk_q[1] & ~sclk_q[2];

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    idle_d    = idle_q;
    rdy_d     = 1'b0;
    byte_d    = byte_q;
    dc_lat_d  = dc_lat_q;
    if (rise) begin
      idle_d  = '0;
      shift_d = {shift_q[5:0], mosi_q[1]};
      if (bit_cnt_q == 3'd7) begin
        byte_d    = {shift_q, mosi_q[1]};
        dc_lat_d  = dc_q[1];
        rdy_d     = 1'b1;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end else begin
      if (idle_q != IW'(TIMEOUT)) idle_d = idle_q + IW'(1);
      // Saturated idle only matters while a byte is half received.
      if (idle_q == IW'(TIMEOUT) && bit_cnt_q != 3'd0) bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q    <= '0;
      mosi_q    <= '0;
      dc_q      <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      idle_q    <= '0;
      rdy_q     <= 1'b0;
      byte_q    <= '0;
      dc_lat_q  <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[1:0], sclk_i};
      mosi_q    <= {mosi_q[0], mosi_i};
      dc_q      <= {dc_q[0], dc_i};
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      idle_q    <= idle_d;
      rdy_q     <= rdy_d;
      byte_q    <= byte_d;
      dc_lat_q  <= dc_lat_d;
    end
  end

  assign byte_rdy_o = rdy_q;
  assign byte_o     = byte_q;
  assign byte_dc_o  = dc_lat_q;
endmodule

// File: rtl/oled_spi_sink.sv
// Display-side SPI sink: decodes an SSD1306 page-addressing command subset and
// writes data bytes into a PAGES x COLS framebuffer.
module oled_spi_sink
  import oled_pkg::*;
#(
  parameter int PAGES   = 4,
  parameter int COLS    = 128,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  oled_spi_sink_if.slave    bus
);
  localparam int PW = $clog2(PAGES);
  localparam int CW = $clog2(COLS);

  logic       byte_rdy, byte_dc;
  logic [7:0] rx_byte;

  spi_byte_rx #(.TIMEOUT(TIMEOUT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .sclk_i     (bus.sclk),
    .mosi_i     (bus.mosi),
    .dc_i       (bus.dc),
    .byte_rdy_o (byte_rdy),
    .byte_o     (rx_byte),
    .byte_dc_o  (byte_dc)
  );

  pstate_t          state_q, state_d;
  kind_t            kind_q, kind_d;
  logic [CW-1:0]    col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PW-1:0]    page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic             disp_on_q, disp_on_d;
  logic             fb_we_q, fb_we_d, frame_done_q, frame_done_d, cmd_valid_q, cmd_valid_d;
  logic [PW+CW-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]       fb_wdata_q, fb_wdata_d, cmd_byte_q, cmd_byte_d;
  logic [CW-1:0]    byte_col;
  logic [PW-1:0]    byte_page;

  assign byte_col  = CW'(32'(rx_byte) % COLS);
  assign byte_page = PW'(32'(rx_byte) % PAGES);

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    col_d        = col_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_d       = page_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    disp_on_d    = disp_on_q;
    fb_we_d      = 1'b0;
    frame_done_d = 1'b0;
    cmd_valid_d  = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_wdata_d   = fb_wdata_q;
    cmd_byte_d   = cmd_byte_q;

    if (byte_rdy && byte_dc && state_q == P_CMD) begin
      fb_we_d      = 1'b1;
      fb_addr_d    = {page_q, col_q};
      fb_wdata_d   = rx_byte;
      frame_done_d = (col_q == col_end_q) && (page_q == page_end_q);
      if (col_q == col_end_q) begin
        col_d  = col_start_q;
        page_d = (page_q == page_end_q) ? page_start_q : page_q + PW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else if (byte_rdy && !byte_dc) begin
      cmd_valid_d = 1'b1;
      cmd_byte_d  = rx_byte;
      unique case (state_q)
        P_CMD: begin
          if (rx_byte[7:3] == CMD_PAGE_BASE[7:3]) begin
            page_d = byte_page;
          end else if (rx_byte[7:4] == 4'h0) begin
            col_d[3:0] = rx_byte[3:0];
          end else if (rx_byte[7:4] == 4'h1) begin
            col_d[CW-1:4] = (CW-4)'(rx_byte[3:0]);
          end else if (rx_byte == CMD_DISP_OFF) begin
            disp_on_d = 1'b0;
          end else if (rx_byte == CMD_DISP_ON) begin
            disp_on_d = 1'b1;
          end else if (rx_byte == CMD_COL_ADDR) begin
            state_d = P_ARG1;
            kind_d  = K_COL;
          end else if (rx_byte == CMD_PAGE_ADDR) begin
            state_d = P_ARG1;
            kind_d  = K_PAGE;
          end else if (is_skip1(rx_byte)) begin
            state_d = P_ARG1;
            kind_d  = K_SKIP1;
          end
        end
        P_ARG1: begin
          state_d = P_ARG2;
          if (kind_q == K_COL)       col_start_d  = byte_col;
          else if (kind_q == K_PAGE) page_start_d = byte_page;
          else                       state_d      = P_CMD;
        end
        P_ARG2: begin
          state_d = P_CMD;
          if (kind_q == K_COL) begin
            col_end_d = byte_col;
            col_d     = col_start_q;
          end else if (kind_q == K_PAGE) begin
            page_end_d = byte_page;
            page_d     = page_start_q;
          end
        end
        default: state_d = P_CMD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= P_CMD;
      kind_q       <= K_COL;
      col_q        <= '0;
      col_start_q  <= '0;
      col_end_q    <= '1;
      page_q       <= '0;
      page_start_q <= '0;
      page_end_q   <= '1;
      disp_on_q    <= 1'b0;
      fb_we_q      <= 1'b0;
      frame_done_q <= 1'b0;
      cmd_valid_q  <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= '0;
      cmd_byte_q   <= '0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      col_q        <= col_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_q       <= page_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      disp_on_q    <= disp_on_d;
      fb_we_q      <= fb_we_d;
      frame_done_q <= frame_done_d;
      cmd_valid_q  <= cmd_valid_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
      cmd_byte_q   <= cmd_byte_d;
    end
  end

  assign bus.fb_we      = fb_we_q;
  assign bus.fb_addr    = fb_addr_q;
  assign bus.fb_wdata   = fb_wdata_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd_byte   = cmd_byte_q;
  assign bus.disp_on    = disp_on_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_oled_spi_sink.sv
// Directed bench for oled_spi_sink: drives SPI bytes, logs framebuffer writes
// and command pulses, and compares them with hand-computed expectations.
module tb_oled_spi_sink;
  localparam int PAGES   = 4;
  localparam int COLS    = 128;
  localparam int TIMEOUT = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;

  oled_spi_sink_if #(.PAGES(PAGES), .COLS(COLS)) bus ();

  oled_spi_sink #(.PAGES(PAGES), .COLS(COLS), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] wr_addr[$];
  logic [7:0] wr_data[$];
  int         fd_cnt = 0;
  int         fd_at  = -1;
  int         cv_cnt = 0;

  always @(negedge clk) begin
    if (bus.fb_we) begin
      wr_addr.push_back(bus.fb_addr);
      wr_data.push_back(bus.fb_wdata);
    end
    if (bus.frame_done) begin
      fd_cnt++;
      fd_at = wr_addr.size();
    end
    if (bus.cmd_valid) cv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    fd_cnt = 0;
    fd_at  = -1;
    cv_cnt = 0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input logic dcv);
    for (int i = 0; i < n; i++) begin
      bus.sclk = 1'b0;
      bus.mosi = b[7-i];
      bus.dc   = dcv;
      #40;
      bus.sclk = 1'b1;
      #40;
    end
    bus.sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dcv);
    send_bits(b, 8, dcv);
    #60;
  endtask

  // Last sclk edge aligned 1 ns after a clk edge; lat counts clk edges until a strobe.
  task automatic send_byte_timed(input logic [7:0] b, input logic dcv, output int lat);
    send_bits(b, 7, dcv);
    bus.mosi = b[0];
    #40;
    @(posedge clk);
    #1;
    bus.sclk = 1'b1;
    lat = 0;
    while (lat < 10) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.fb_we || bus.cmd_valid) break;
    end
    #30;
    bus.sclk = 1'b0;
    #60;
  endtask

  initial begin
    int lat;
    int base;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.dc   = 1'b0;
    rst = 1'b0;
    #25;
    check("rst_fb_we", 32'(bus.fb_we), 0);
    check("rst_fb_addr", 32'(bus.fb_addr), 0);
    check("rst_cmd_byte", 32'(bus.cmd_byte), 0);
    check("rst_disp_on", 32'(bus.disp_on), 0);
    @(negedge clk);
    rst = 1'b1;
    #50;

    // Page 2, column 5, then two data bytes.
    clear_log();
    send_byte(8'hB2, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h10, 1'b0);
    check("t1_cmd_byte", 32'(bus.cmd_byte), 32'h10);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    check("t1_cmd_cnt", 32'(cv_cnt), 3);
    check("t1_wr_cnt", 32'(wr_addr.size()), 2);
    if (wr_addr.size() == 2) begin
      check("t1_addr0", 32'(wr_addr[0]), 261);
      check("t1_data0", 32'(wr_data[0]), 32'hA5);
      check("t1_addr1", 32'(wr_addr[1]), 262);
      check("t1_data1", 32'(wr_data[1]), 32'h3C);
    end

    // 16x4 window, 64 bytes fill it, the 65th wraps to the start.
    clear_log();
    send_byte(8'h21, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h0F, 1'b0);
    send_byte(8'h22, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h03, 1'b0);
    check("t2_cmd_cnt", 32'(cv_cnt), 6);
    for (int i = 0; i < 65; i++) send_byte(8'(i), 1'b1);
    check("t2_wr_cnt", 32'(wr_addr.size()), 65);
    if (wr_addr.size() == 65) begin
      for (int i = 0; i < 64; i++)
        check($sformatf("t2_addr%0d", i), 32'(wr_addr[i]), 32'((i / 16) * 128 + (i % 16)));
      check("t2_addr64", 32'(wr_addr[64]), 0);
      check("t2_data64", 32'(wr_data[64]), 64);
    end
    check("t2_fd_cnt", 32'(fd_cnt), 1);
    check("t2_fd_at", 32'(fd_at), 64);

    // Display on/off, with 0xAE hidden as a contrast argument.
    send_byte(8'hAF, 1'b0);
    check("t3_on", 32'(bus.disp_on), 1);
    send_byte(8'h81, 1'b0);
    send_byte(8'hAE, 1'b0);
    check("t3_arg_ae", 32'(bus.disp_on), 1);
    send_byte(8'hAE, 1'b0);
    check("t3_off", 32'(bus.disp_on), 0);

    // Partial byte abandoned by the idle timeout.
    clear_log();
    send_bits(8'hFF, 5, 1'b1);
    repeat (TIMEOUT + 10) @(posedge clk);
    #1;
    send_byte(8'h81, 1'b1);
    #200;
    check("t4_wr_cnt", 32'(wr_addr.size()), 1);
    if (wr_addr.size() >= 1) begin
      check("t4_data", 32'(wr_data[0]), 32'h81);
      check("t4_addr", 32'(wr_addr[0]), 1);
    end

    // Data inside an argument slot is ignored; page window becomes 1..2.
    clear_log();
    send_byte(8'h22, 1'b0);
    send_byte(8'h77, 1'b1);
    check("t5_ignored", 32'(wr_addr.size()), 0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h99, 1'b1);
    check("t5_wr_cnt", 32'(wr_addr.size()), 1);
    if (wr_addr.size() >= 1) begin
      check("t5_addr", 32'(wr_addr[0]), 130);
      check("t5_data", 32'(wr_data[0]), 32'h99);
    end
    check("t5_cmd_cnt", 32'(cv_cnt), 3);

    // Reset in the middle of a byte, then a clean byte with latency check.
    send_bits(8'hFF, 5, 1'b1);
    bus.mosi = 1'b1;
    #20;
    rst = 1'b0;
    #30;
    check("t6_rst_addr", 32'(bus.fb_addr), 0);
    check("t6_rst_cmd", 32'(bus.cmd_byte), 0);
    @(negedge clk);
    rst = 1'b1;
    #50;
    clear_log();
    send_byte_timed(8'h40, 1'b1, lat);
    check("t6_latency", 32'(lat), 4);
    check("t6_wr_cnt", 32'(wr_addr.size()), 1);
    if (wr_addr.size() >= 1) begin
      check("t6_addr", 32'(wr_addr[0]), 0);
      check("t6_data", 32'(wr_data[0]), 32'h40);
    end
    base = cv_cnt;
    check("t6_no_cmd", 32'(base), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
